// File: rtl/store_merge_if.sv
// Store request / data memory bundle for store_merge.
// The DUT attaches through the slave modport; the requester and the memory
// model attach through the master modport.
//
// Handshake: a request transfers on a rising CPU_CLK edge where ReqValid and
// ReqReady are both high. ReqReady depends only on the block's state, never
// on ReqValid. The requester holds ReqValid and the request fields stable
// until that edge. ReqValid seen while ReqReady is low is ignored.
interface store_merge_if #(
  parameter int WADDR_W = 12
);
  logic               ReqValid;
  logic               ReqReady;
  logic [1:0]         ReqType;
  logic [31:0]        ReqAddr;
  logic [31:0]        ReqData;
  logic               Busy;
  logic               MisalignErr;
  logic [WADDR_W-1:0] MemAddr;
  logic               MemRe;
  logic [31:0]        MemRdata;
  logic               MemWe;
  logic [31:0]        MemWdata;

  modport master (
    output ReqValid, ReqType, ReqAddr, ReqData, MemRdata,
    input  ReqReady, Busy, MisalignErr, MemAddr, MemRe, MemWe, MemWdata
  );

  modport slave (
    input  ReqValid, ReqType, ReqAddr, ReqData, MemRdata,
    output ReqReady, Busy, MisalignErr, MemAddr, MemRe, MemWe, MemWdata
  );
endinterface

// File: rtl/store_merge.sv
// store_merge: places SB/SH/SW store data on the correct byte lanes and
// writes a word-only data memory. Sub-word stores do a read-modify-write
// (READ -> MERGE -> WRITE); full-word stores go straight to WRITE.
// Misaligned or reserved requests are dropped with a one-cycle MisalignErr.
//
// Optional feature, macro STORE_FWD_EN: a one-entry buffer holding the last
// written word and its word address. A sub-word store that hits it skips
// READ and merges into the buffered word instead of MemRdata.
module store_merge #(
  parameter int WADDR_W = 12
) (
  input  logic         CPU_CLK,
  input  logic         CPU_RST,
  store_merge_if.slave bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    MERGE = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [1:0] TYPE_SB = 2'b00;
  localparam logic [1:0] TYPE_SH = 2'b01;
  localparam logic [1:0] TYPE_SW = 2'b10;

  state_t             state;
  state_t             state_next;

  // Latched request
  logic [WADDR_W-1:0] addr_q;
  logic [1:0]         type_q;
  logic [1:0]         lane_q;
  logic [15:0]        data_q;
  logic [31:0]        wdata_q;
  logic               err_q;

  // Request decode
  logic               accept;
  logic               req_bad;
  logic               fwd_hit;
  logic [WADDR_W-1:0] req_wa;
  logic [31:0]        merge_src;
  logic [31:0]        merged;

  // Address bits above the memory's word range do not take part in the store.
  logic               unused_addr_hi;
  assign unused_addr_hi = ^bus.ReqAddr[31:WADDR_W+2];

`ifdef STORE_FWD_EN
  logic               fwd_valid;
  logic [WADDR_W-1:0] fwd_addr;
  logic [31:0]        fwd_data;
  logic               fwd_hit_q;
`endif

  // Classify the incoming request: alignment / reserved-type check
  always_comb begin
    req_wa = bus.ReqAddr[WADDR_W+1:2];
    accept = (state == IDLE) && bus.ReqValid;
    case (bus.ReqType)
      TYPE_SB: req_bad = 1'b0;
      TYPE_SH: req_bad = bus.ReqAddr[0];
      TYPE_SW: req_bad = |bus.ReqAddr[1:0];
      default: req_bad = 1'b1;
    endcase
`ifdef STORE_FWD_EN
    fwd_hit = fwd_valid && (fwd_addr == req_wa) && (bus.ReqType != TYPE_SW);
`else
    fwd_hit = 1'b0;
`endif
  end

  // State register; reset abandons any store in flight
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !req_bad) begin
          if (bus.ReqType == TYPE_SW) begin
            state_next = WRITE;
          end else if (fwd_hit) begin
            state_next = MERGE;
          end else begin
            state_next = READ;
          end
        end
      end
      READ:    state_next = MERGE;
      MERGE:   state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs; strobes fall with the async reset of state
  always_comb begin
    bus.ReqReady    = (state == IDLE);
    bus.Busy        = (state != IDLE);
    bus.MemRe       = (state == READ);
    bus.MemWe       = (state == WRITE);
    bus.MisalignErr = err_q;
    bus.MemAddr     = addr_q;
    bus.MemWdata    = wdata_q;
    state_dbg       = state;
  end

  // Lane merge: replace the addressed byte / half, keep every other bit
  always_comb begin
    merge_src = bus.MemRdata;
`ifdef STORE_FWD_EN
    if (fwd_hit_q) begin
      merge_src = fwd_data;
    end
`endif
    merged = merge_src;
    case (type_q)
      TYPE_SB: begin
        case (lane_q)
          2'd0:    merged[7:0]   = data_q[7:0];
          2'd1:    merged[15:8]  = data_q[7:0];
          2'd2:    merged[23:16] = data_q[7:0];
          default: merged[31:24] = data_q[7:0];
        endcase
      end
      TYPE_SH: begin
        if (lane_q[1]) begin
          merged[31:16] = data_q;
        end else begin
          merged[15:0] = data_q;
        end
      end
      default: merged = merge_src;
    endcase
  end

  // Request latch, write-word register and error pulse
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      addr_q  <= '0;
      type_q  <= '0;
      lane_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && req_bad;
      if (accept) begin
        addr_q <= req_wa;
        type_q <= bus.ReqType;
        lane_q <= bus.ReqAddr[1:0];
        data_q <= bus.ReqData[15:0];
        if (!req_bad && (bus.ReqType == TYPE_SW)) begin
          wdata_q <= bus.ReqData;
        end
      end
      if (state == MERGE) begin
        wdata_q <= merged;
      end
    end
  end

`ifdef STORE_FWD_EN
  // Forward buffer: mirrors the word committed by every WRITE
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      fwd_data  <= '0;
      fwd_hit_q <= 1'b0;
    end else begin
      if (accept) begin
        fwd_hit_q <= fwd_hit;
      end
      if (state == WRITE) begin
        fwd_valid <= 1'b1;
        fwd_addr  <= addr_q;
        fwd_data  <= wdata_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_store_merge.sv
// Bench for store_merge: directed scenarios followed by random stores,
// checked against a word-array reference model with a forward-buffer flag.
module tb_store_merge;

`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       CPU_CLK = 1'b0;
  logic       CPU_RST = 1'b1;
  logic [1:0] state_dbg;

  store_merge_if #(.WADDR_W(12)) bus ();

  store_merge #(.WADDR_W(12)) dut (
    .CPU_CLK  (CPU_CLK),
    .CPU_RST  (CPU_RST),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 CPU_CLK = ~CPU_CLK;

  int cyc = 0;
  always @(posedge CPU_CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- memory environment ----------------
  logic [31:0] mem [0:4095];
  always @(posedge CPU_CLK) begin
    if (bus.MemRe) bus.MemRdata <= mem[bus.MemAddr];
    if (bus.MemWe) mem[bus.MemAddr] <= bus.MemWdata;
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:4095];
  bit          fv = 1'b0;
  logic [11:0] fa = '0;
  int          busy_exp = 0;
  int          last_lat = 0;

  // exp_q: {write cycle[19:0], word addr[11:0], data[31:0]}
  logic [63:0] exp_q[$];
  // re_q: {word addr[11:0], read cycle[19:0]}
  logic [31:0] re_q[$];
  logic [31:0] err_q[$];

  task automatic model_accept(input logic [1:0] t, input logic [31:0] a,
                              input logic [31:0] d, input int c);
    logic [11:0] wa;
    logic [31:0] word;
    int          lane;
    bit          bad;
    bit          hit;
    int          lat;
    wa   = a[13:2];
    lane = int'(a[1:0]);
    bad  = (t == 2'b11) || (t == 2'b01 && a[0]) || (t == 2'b10 && a[1:0] != 2'b00);
    if (bad) begin
      err_q.push_back(c + 1);
      last_lat = 0;
      return;
    end
    word = ref_mem[wa];
    if (t == 2'b00) word[lane*8 +: 8] = d[7:0];
    else if (t == 2'b01) word[(lane/2)*16 +: 16] = d[15:0];
    else word = d;
    hit = FWD && fv && (fa == wa) && (t != 2'b10);
    lat = (t == 2'b10) ? 1 : (hit ? 2 : 3);
    if (t != 2'b10 && !hit) begin
      int rc = c + 1;
      re_q.push_back({wa, rc[19:0]});
    end
    begin
      int wc = c + lat;
      exp_q.push_back({wc[19:0], wa, word});
    end
    ref_mem[wa] = word;
    fv = 1'b1;
    fa = wa;
    busy_exp += lat;
    last_lat = lat;
  endtask

  // ---------------- monitor ----------------
  int busy_act    = 0;
  int last_we_cyc = 0;

  always @(negedge CPU_CLK) begin
    logic [63:0] e;
    logic [31:0] r;
    if (bus.MemRe || bus.MemWe) check("re_we_excl", {31'b0, bus.MemRe & bus.MemWe}, 32'd0);
    if (bus.Busy) busy_act++;
    if (bus.MemWe) begin
      check("we_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("we_cycle", cyc, {12'b0, e[63:44]});
        check("we_addr", {20'b0, bus.MemAddr}, {20'b0, e[43:32]});
        check("we_data", bus.MemWdata, e[31:0]);
        last_we_cyc = cyc;
      end
    end
    if (bus.MemRe) begin
      check("re_expected", {31'b0, re_q.size() != 0}, 32'd1);
      if (re_q.size() != 0) begin
        r = re_q.pop_front();
        check("re_cycle", cyc, {12'b0, r[19:0]});
        check("re_addr", {20'b0, bus.MemAddr}, {20'b0, r[31:20]});
      end
    end
    if (bus.MisalignErr) begin
      check("err_expected", {31'b0, err_q.size() != 0}, 32'd1);
      if (err_q.size() != 0) check("err_cycle", cyc, err_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a request and waits for it to be taken; ReqValid stays high on
  // return so a following call can continue back-to-back.
  task automatic issue(input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] d, output int acc);
    int n = 0;
    bus.ReqValid = 1'b1;
    bus.ReqType  = t;
    bus.ReqAddr  = a;
    bus.ReqData  = d;
    while (!bus.ReqReady && n < 20) begin
      @(negedge CPU_CLK);
      n++;
    end
    check("accept_ready", {31'b0, bus.ReqReady}, 32'd1);
    acc = cyc;
    if (bus.ReqReady) model_accept(t, a, d, cyc);
    @(posedge CPU_CLK);
    #1;
  endtask

  task automatic drop_req();
    bus.ReqValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    drop_req();
    @(negedge CPU_CLK);
    while ((exp_q.size() != 0 || re_q.size() != 0 || err_q.size() != 0 || !bus.ReqReady) && n < 40) begin
      @(negedge CPU_CLK);
      n++;
    end
    check("drain_exp_q", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  {31'b0, bus.ReqReady},    32'd1);
    check({tag, "_busy"},   {31'b0, bus.Busy},        32'd0);
    check({tag, "_err"},    {31'b0, bus.MisalignErr}, 32'd0);
    check({tag, "_re"},     {31'b0, bus.MemRe},       32'd0);
    check({tag, "_we"},     {31'b0, bus.MemWe},       32'd0);
    check({tag, "_addr"},   {20'b0, bus.MemAddr},     32'd0);
    check({tag, "_wdata"},  bus.MemWdata,             32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a0, a1, a2;
    logic [31:0] saved;
    int n;

    bus.ReqValid = 1'b0;
    bus.ReqType  = '0;
    bus.ReqAddr  = '0;
    bus.ReqData  = '0;
    bus.MemRdata = '0;
    for (int i = 0; i < 4096; i++) begin
      logic [31:0] v;
      v = $urandom();
      mem[i]     = v;
      ref_mem[i] = v;
    end

    repeat (3) @(negedge CPU_CLK);
    check_reset_outputs("rst");
    CPU_RST = 1'b0;
    @(negedge CPU_CLK);

    // Full-word store
    issue(2'b10, 32'h100, 32'hDEADBEEF, a0);
    drain();
    check("sw_mem", mem[12'h040], 32'hDEADBEEF);

    // Byte store into 0x11223344
    issue(2'b10, 32'h100, 32'h11223344, a0);
    drain();
    issue(2'b00, 32'h102, 32'h000000AB, a0);
    drain();
    check("sb_mem", mem[12'h040], 32'h11AB3344);
    check("sb_lat", last_we_cyc - a0, FWD ? 32'd2 : 32'd3);

    // Half store, then misaligned half
    issue(2'b10, 32'h100, 32'h11223344, a0);
    drain();
    issue(2'b01, 32'h102, 32'h0000BEEF, a0);
    drain();
    check("sh_mem", mem[12'h040], 32'hBEEF3344);
    issue(2'b01, 32'h101, 32'h00001234, a0);
    drop_req();
    @(negedge CPU_CLK);
    check("mis_err", {31'b0, bus.MisalignErr}, 32'd1);
    check("mis_busy", {31'b0, bus.Busy}, 32'd0);
    drain();
    check("mis_mem", mem[12'h040], 32'hBEEF3344);

    // Reset during MERGE abandons the store
    saved = ref_mem[12'h040];
    issue(2'b00, 32'h103, 32'h000000C3, a0);
    drop_req();
    n = 0;
    @(negedge CPU_CLK);
    while (!(bus.Busy && !bus.MemRe && !bus.MemWe) && n < 10) begin
      @(negedge CPU_CLK);
      n++;
    end
    check("rst_in_merge", {31'b0, bus.Busy && !bus.MemRe && !bus.MemWe}, 32'd1);
    CPU_RST = 1'b1;
    void'(exp_q.pop_back());
    ref_mem[12'h040] = saved;
    fv = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge CPU_CLK);
    CPU_RST = 1'b0;
    check("rst_no_write", mem[12'h040], saved);
    @(posedge CPU_CLK);
    #1;
    busy_act = 0;
    busy_exp = 0;
    issue(2'b10, 32'h104, 32'hCAFEF00D, a0);
    drain();
    check("post_rst_sw", mem[12'h041], 32'hCAFEF00D);

    // Forwarded sub-word store
    issue(2'b10, 32'h100, 32'h11223344, a0);
    drain();
    issue(2'b00, 32'h100, 32'h00000055, a0);
    drain();
    check("fwd_mem", mem[12'h040], 32'h11223355);
    check("fwd_lat", last_we_cyc - a0, FWD ? 32'd2 : 32'd3);

    // Back-to-back SW, SB, SW with ReqValid held
    issue(2'b10, 32'h200, 32'hA5A5A5A5, a0);
    issue(2'b00, 32'h205, 32'h00000077, a1);
    issue(2'b10, 32'h208, 32'h5A5A5A5A, a2);
    drain();
    check("b2b_gap1", a1 - a0, 32'd2);
    check("b2b_gap2", a2 - a0, 32'd6);
    check("b2b_mem0", mem[12'h080], 32'hA5A5A5A5);
    check("b2b_mem2", mem[12'h082], 32'h5A5A5A5A);

    // Random stores over a few words so forwarding hits happen
    for (int i = 0; i < 200; i++) begin
      logic [1:0]  t;
      logic [31:0] a;
      logic [31:0] d;
      t = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0 && t == 2'b11) t = 2'b00;
      a = ($urandom() & 32'hFFFF_C000) | (32'h100 + $urandom_range(0, 15));
      if (t != 2'b00 && $urandom_range(0, 2) != 0) a[1:0] = (t == 2'b01) ? {a[1], 1'b0} : 2'b00;
      d = $urandom();
      if ($urandom_range(0, 1) == 0) begin
        drop_req();
        repeat ($urandom_range(0, 3)) @(negedge CPU_CLK);
      end
      issue(t, a, d, a0);
    end
    drain();
    for (int w = 12'h040; w < 12'h044; w++) check("rand_mem", mem[w], ref_mem[w]);
    check("re_q_empty", re_q.size(), 32'd0);
    check("err_q_empty", err_q.size(), 32'd0);
    check("busy_cycles", busy_act, busy_exp);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/store_merge.md
# store_merge

Store-side counterpart of the load extension path. Takes SB/SH/SW requests from the MEM stage, places store data on the correct byte lanes, and writes a word-only data memory (no byte enables) via read-modify-write for sub-word stores. Sits between the MEM-stage store controls and the data memory write port. Stalls the pipeline through `Busy` while a store is in progress.

## Interface
Parameters:
- `WADDR_W`, default 12: word-address width of the data memory (4K words).

Ports:
- `CPU_CLK`  in  1  clock; all state updates on the rising edge.
- `CPU_RST`  in  1  asynchronous, active-high reset.
- `ReqValid`  in  1  store request present.
- `ReqReady`  out  1  request accepted this cycle; high only in IDLE.
- `ReqType`  in  2  store type: 00 SB, 01 SH, 10 SW, 11 reserved.
- `ReqAddr`  in  32  byte address.
- `ReqData`  in  32  rs2 value; the low byte or half-word is used for SB/SH.
- `Busy`  out  1  high in every state other than IDLE.
- `MisalignErr`  out  1  one-cycle error pulse for a dropped request.
- `MemAddr`  out  WADDR_W  word address, `ReqAddr[WADDR_W+1:2]`, registered.
- `MemRe`  out  1  read strobe. Read data returns on `MemRdata` one cycle later.
- `MemRdata`  in  32  read data from memory.
- `MemWe`  out  1  write strobe, one cycle per store.
- `MemWdata`  out  32  merged write word.

## Operation
- States: IDLE, READ, MERGE, WRITE.
- **IDLE**, when `ReqValid` is high:
  - Latch address, type, data and lane `ReqAddr[1:0]`.
  - Misaligned or reserved requests are dropped. This covers SH with `addr[0]=1`, SW with `addr[1:0]!=0`, and type 11. The block stays in IDLE and pulses `MisalignErr` in the following cycle.
  - SW goes to WRITE with the full word.
  - SB and SH go to READ.
- **READ**:
  - `MemRe=1` with the latched `MemAddr`.
  - Next state is MERGE.
- **MERGE**:
  - Capture `MemRdata`.
  - Replace lane bytes: SB replaces byte `lane` with `ReqData[7:0]`; SH replaces half `lane[1]` with `ReqData[15:0]`.
  - Other bytes are preserved bit-exactly.
  - Next state is WRITE.
- **WRITE**:
  - `MemWe=1` and `MemWdata` = merged word.
  - Next state is IDLE.
- Requests are processed one at a time. `ReqValid` outside IDLE is ignored; the requester must hold it until `ReqReady`.

## Timing
- Reset values:
  - State IDLE.
  - `ReqReady`=1 (combinational from IDLE).
  - `Busy`=0, `MisalignErr`=0, `MemRe`=0, `MemWe`=0.
  - `MemAddr`=0, `MemWdata`=0.
  - Forward-valid flag cleared.
- SW: accept at cycle 0, `MemWe` at cycle 1. `Busy` is high for 1 cycle.
- SB/SH, no forward hit:
  - Accept at cycle 0.
  - `MemRe` at cycle 1.
  - Merge at cycle 2.
  - `MemWe` at cycle 3.
  - `Busy` is high for 3 cycles.
- Misaligned request: `ReqReady`=1 at acceptance, `MisalignErr`=1 for exactly 1 cycle, no memory strobe. `Busy` stays 0.
- A new request is accepted in the cycle after WRITE, giving back-to-back stores with no idle bubble.
- `MemRe` and `MemWe` are never high in the same cycle.
- Reset asserted mid-operation forces IDLE immediately. A pending write is abandoned and no partial write occurs; `MemWe` drops asynchronously.

## Configuration
- `STORE_FWD_EN` defined:
  - The block keeps the last written word and its word address in a one-entry buffer, valid after any WRITE.
  - An SB/SH whose word address matches a valid entry skips READ: IDLE goes to MERGE, and the merge source is the buffer instead of `MemRdata`.
  - Sub-word store latency drops to 2 cycles; `MemRe` is not asserted.
  - SW always updates the buffer.
  - Reset clears the buffer valid flag.
- `STORE_FWD_EN` undefined: no buffer; every SB/SH performs READ.

## Test plan
- SW `0xDEADBEEF` to `0x100` -> `MemWe` at cycle 1, `MemAddr=0x040`, `MemWdata=0xDEADBEEF`, `MemRe` never high.
- Memory word `0x11223344` at `0x100`; SB `0xAB` to `0x102` -> `MemRe` at cycle 1, `MemWe` at cycle 3 with `0x11AB3344`.
- Same memory word; SH `0xBEEF` to `0x102` -> `0xBEEF3344`. Then SH to `0x101` -> `MisalignErr` pulse, no `MemRe`/`MemWe`, `Busy=0`.
- SB to `0x103` with `CPU_RST` raised in MERGE -> all outputs return to reset values; no `MemWe` issued; the next SW completes normally.
- With `STORE_FWD_EN`: SW `0x11223344` to `0x100`, then SB `0x55` to `0x100` -> no `MemRe`, `MemWe` at cycle 2 with `0x11223355`. Without the macro, the same sequence reads first and writes at cycle 3.
- Back-to-back SW, SB, SW, each with `ReqValid` held high -> `ReqReady` at cycles 0, 2 and 6; three writes in order with the correct data.
